// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and default bus widths for master, slave and bench code.
// The width macros keep a project-level override but fall back to 32-bit buses.
`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif

package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'b000,
        HSIZE_HALF  = 3'b001,
        HSIZE_WORD  = 3'b010,
        HSIZE_DWORD = 3'b011,
        HSIZE_4W    = 3'b100,
        HSIZE_8W    = 3'b101,
        HSIZE_16W   = 3'b110,
        HSIZE_32W   = 3'b111
    } hsize_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb_master_ctrl.sv
// AHB-Lite initiator: turns a valid/ready command stream into SINGLE transfers with
// the next address phase overlapped on the current data phase, plus two-cycle ERROR handling.
module ahb_master_ctrl
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = `AHB_ADDR_WIDTH,
    parameter int DATA_WIDTH = `AHB_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [2:0]              cmd_size,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
`ifdef AHB_PROT
    input  logic [3:0]              cmd_prot,
`endif
`ifdef AHB_WSTRB
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
`endif
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_error,
    output logic [ADDR_WIDTH-1:0]   haddr,
    output logic [1:0]              htrans,
    output logic                    hwrite,
    output logic [2:0]              hsize,
    output logic [2:0]              hburst,
`ifdef AHB_PROT
    output logic [3:0]              hprot,
`endif
`ifdef AHB_WSTRB
    output logic [DATA_WIDTH/8-1:0] hwstrb,
`endif
    output logic [DATA_WIDTH-1:0]   hwdata,
    input  logic                    hready,
    input  logic                    hresp,
    input  logic [DATA_WIDTH-1:0]   hrdata
);

    // Address-phase stage
    logic                    aph_valid_reg, aph_valid_next;
    logic                    aph_write_reg, aph_write_next;
    logic [ADDR_WIDTH-1:0]   aph_addr_reg,  aph_addr_next;
    logic [2:0]              aph_size_reg,  aph_size_next;
    logic [DATA_WIDTH-1:0]   aph_wdata_reg, aph_wdata_next;
`ifdef AHB_PROT
    logic [3:0]              aph_prot_reg,  aph_prot_next;
`endif
`ifdef AHB_WSTRB
    logic [DATA_WIDTH/8-1:0] aph_strb_reg,  aph_strb_next;
    logic [DATA_WIDTH/8-1:0] dph_strb_reg,  dph_strb_next;
`endif
    // Data-phase stage
    logic                    dph_valid_reg, dph_valid_next;
    logic                    dph_write_reg, dph_write_next;
    logic [DATA_WIDTH-1:0]   dph_wdata_reg, dph_wdata_next;
    // Set during the first ERROR cycle; forces IDLE for the second one
    logic                    cancel_reg,    cancel_next;
    logic                    rsp_valid_reg, rsp_valid_next;
    logic                    rsp_error_reg, rsp_error_next;
    logic [DATA_WIDTH-1:0]   rsp_rdata_reg, rsp_rdata_next;
    logic                    accept;
    logic                    forward;

    assign cmd_ready = !rst && !cancel_reg && (!aph_valid_reg || hready);
    assign accept    = cmd_valid && cmd_ready;
    assign forward   = aph_valid_reg && !cancel_reg;

    always_comb begin
        aph_valid_next = aph_valid_reg;
        aph_write_next = aph_write_reg;
        aph_addr_next  = aph_addr_reg;
        aph_size_next  = aph_size_reg;
        aph_wdata_next = aph_wdata_reg;
`ifdef AHB_PROT
        aph_prot_next  = aph_prot_reg;
`endif
`ifdef AHB_WSTRB
        aph_strb_next  = aph_strb_reg;
        dph_strb_next  = dph_strb_reg;
`endif
        dph_valid_next = dph_valid_reg;
        dph_write_next = dph_write_reg;
        dph_wdata_next = dph_wdata_reg;
        cancel_next    = cancel_reg;
        rsp_valid_next = 1'b0;
        rsp_error_next = 1'b0;
        rsp_rdata_next = '0;

        if (hready) begin
            dph_valid_next = forward;
            if (forward) begin
                dph_write_next = aph_write_reg;
                dph_wdata_next = aph_wdata_reg;
`ifdef AHB_WSTRB
                dph_strb_next  = aph_strb_reg;
`endif
            end
            if (dph_valid_reg) begin
                rsp_valid_next = 1'b1;
                rsp_error_next = hresp;
                rsp_rdata_next = dph_write_reg ? '0 : hrdata;
            end
            // A cancelled command stays in the address stage to be reissued
            if (!cancel_reg) begin
                aph_valid_next = 1'b0;
            end
            cancel_next = 1'b0;
        end else if (hresp == HRESP_ERROR && dph_valid_reg) begin
            cancel_next = 1'b1;
        end

        if (accept) begin
            aph_valid_next = 1'b1;
            aph_write_next = cmd_write;
            aph_addr_next  = cmd_addr;
            aph_size_next  = cmd_size;
            aph_wdata_next = cmd_write ? cmd_wdata : '0;
`ifdef AHB_PROT
            aph_prot_next  = cmd_prot;
`endif
`ifdef AHB_WSTRB
            aph_strb_next  = cmd_write ? cmd_strb : '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aph_valid_reg <= 1'b0;
            aph_write_reg <= 1'b0;
            aph_addr_reg  <= '0;
            aph_size_reg  <= '0;
            aph_wdata_reg <= '0;
`ifdef AHB_PROT
            aph_prot_reg  <= '0;
`endif
`ifdef AHB_WSTRB
            aph_strb_reg  <= '0;
            dph_strb_reg  <= '0;
`endif
            dph_valid_reg <= 1'b0;
            dph_write_reg <= 1'b0;
            dph_wdata_reg <= '0;
            cancel_reg    <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_error_reg <= 1'b0;
            rsp_rdata_reg <= '0;
        end else begin
            aph_valid_reg <= aph_valid_next;
            aph_write_reg <= aph_write_next;
            aph_addr_reg  <= aph_addr_next;
            aph_size_reg  <= aph_size_next;
            aph_wdata_reg <= aph_wdata_next;
`ifdef AHB_PROT
            aph_prot_reg  <= aph_prot_next;
`endif
`ifdef AHB_WSTRB
            aph_strb_reg  <= aph_strb_next;
            dph_strb_reg  <= dph_strb_next;
`endif
            dph_valid_reg <= dph_valid_next;
            dph_write_reg <= dph_write_next;
            dph_wdata_reg <= dph_wdata_next;
            cancel_reg    <= cancel_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_error_reg <= rsp_error_next;
            rsp_rdata_reg <= rsp_rdata_next;
        end
    end

    assign haddr     = aph_addr_reg;
    assign htrans    = forward ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign hwrite    = aph_write_reg;
    assign hsize     = aph_size_reg;
    assign hburst    = HBURST_SINGLE;
`ifdef AHB_PROT
    assign hprot     = aph_prot_reg;
`endif
`ifdef AHB_WSTRB
    assign hwstrb    = dph_strb_reg;
`endif
    assign hwdata    = dph_wdata_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_error = rsp_error_reg;
    assign rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_ahb_master_ctrl.sv
// Directed scenarios plus a randomized run where a bus monitor/scoreboard predicts
// the transfer order and the response that must follow each completed data phase.
module tb_ahb_master_ctrl;
    import ahb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [2:0]    cmd_size;
    logic [DW-1:0] cmd_wdata;
`ifdef AHB_PROT
    logic [3:0]    cmd_prot, hprot;
`endif
`ifdef AHB_WSTRB
    logic [DW/8-1:0] cmd_strb, hwstrb;
`endif
    logic          rsp_valid, rsp_error;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize, hburst;
    logic [DW-1:0] hwdata;
    logic          hready, hresp;
    logic [DW-1:0] hrdata;

    int checks_total  = 0;
    int checks_passed = 0;

    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [2:0]    s;
    } cmd_t;

    ahb_master_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
`ifdef AHB_PROT
        .cmd_prot(cmd_prot), .hprot(hprot),
`endif
`ifdef AHB_WSTRB
        .cmd_strb(cmd_strb), .hwstrb(hwstrb),
`endif
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
        .hburst(hburst), .hwdata(hwdata),
        .hready(hready), .hresp(hresp), .hrdata(hrdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [2:0] s);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_size  = s;
`ifdef AHB_PROT
        cmd_prot  = 4'h3;
`endif
`ifdef AHB_WSTRB
        cmd_strb  = '1;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b1;
        tick(); tick();
        checks_total++; if (cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready: got %b expected 0", cmd_ready); else checks_passed++;
        checks_total++; if (htrans !== 2'b00) $display("FAIL rst_htrans: got %b expected 00", htrans); else checks_passed++;
        checks_total++; if (haddr !== 32'h0) $display("FAIL rst_haddr: got %h expected 0", haddr); else checks_passed++;
        checks_total++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); else checks_passed++;
        checks_total++; if (hburst !== 3'b000) $display("FAIL rst_hburst: got %b expected 000", hburst); else checks_passed++;
        cmd_valid = 1'b0; rst = 1'b0;
        #1;
        checks_total++; if (cmd_ready !== 1'b1) $display("FAIL rst_release_ready: got %b expected 1", cmd_ready); else checks_passed++;
        tick();
    endtask

    task automatic test_zero_wait_write();
        set_cmd(1'b1, 32'h100, 32'hDEADBEEF, 3'd2);
        #1;
        checks_total++; if (cmd_ready !== 1'b1) $display("FAIL zw_cmd_ready: got %b expected 1", cmd_ready); else checks_passed++;
        tick(); cmd_valid = 1'b0;
        checks_total++; if (htrans !== 2'b10) $display("FAIL zw_htrans: got %b expected 10", htrans); else checks_passed++;
        checks_total++; if (haddr !== 32'h100) $display("FAIL zw_haddr: got %h expected 100", haddr); else checks_passed++;
        checks_total++; if (hwrite !== 1'b1) $display("FAIL zw_hwrite: got %b expected 1", hwrite); else checks_passed++;
        checks_total++; if (hsize !== 3'd2) $display("FAIL zw_hsize: got %0d expected 2", hsize); else checks_passed++;
        tick();
        checks_total++; if (hwdata !== 32'hDEADBEEF) $display("FAIL zw_hwdata: got %h expected deadbeef", hwdata); else checks_passed++;
        checks_total++; if (htrans !== 2'b00) $display("FAIL zw_idle_after: got %b expected 00", htrans); else checks_passed++;
        checks_total++; if (rsp_valid !== 1'b0) $display("FAIL zw_rsp_early: got %b expected 0", rsp_valid); else checks_passed++;
        tick();
        checks_total++; if (rsp_valid !== 1'b1) $display("FAIL zw_rsp_valid: got %b expected 1", rsp_valid); else checks_passed++;
        checks_total++; if (rsp_error !== 1'b0 || rsp_rdata !== 32'h0) $display("FAIL zw_rsp_data: got err=%b data=%h expected err=0 data=0", rsp_error, rsp_rdata); else checks_passed++;
        tick();
        checks_total++; if (rsp_valid !== 1'b0) $display("FAIL zw_rsp_pulse: got %b expected 0", rsp_valid); else checks_passed++;
    endtask

    task automatic test_back_to_back();
        set_cmd(1'b0, 32'h200, 32'h0, 3'd2);
        tick();
        set_cmd(1'b1, 32'h204, 32'h55AA55AA, 3'd2);
        #1;
        checks_total++; if (htrans !== 2'b10 || haddr !== 32'h200 || hwrite !== 1'b0) $display("FAIL b2b_rd_addr: got %b/%h/%b expected 10/200/0", htrans, haddr, hwrite); else checks_passed++;
        checks_total++; if (cmd_ready !== 1'b1) $display("FAIL b2b_cmd_ready: got %b expected 1", cmd_ready); else checks_passed++;
        tick(); cmd_valid = 1'b0; hrdata = 32'hCAFEF00D;
        checks_total++; if (htrans !== 2'b10 || haddr !== 32'h204 || hwrite !== 1'b1) $display("FAIL b2b_wr_addr: got %b/%h/%b expected 10/204/1", htrans, haddr, hwrite); else checks_passed++;
        tick(); hrdata = 32'h0;
        checks_total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFEF00D || rsp_error !== 1'b0) $display("FAIL b2b_rd_rsp: got v=%b d=%h e=%b expected v=1 d=cafef00d e=0", rsp_valid, rsp_rdata, rsp_error); else checks_passed++;
        checks_total++; if (hwdata !== 32'h55AA55AA) $display("FAIL b2b_hwdata: got %h expected 55aa55aa", hwdata); else checks_passed++;
        tick();
        checks_total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) $display("FAIL b2b_wr_rsp: got v=%b d=%h expected v=1 d=0", rsp_valid, rsp_rdata); else checks_passed++;
        tick();
        checks_total++; if (rsp_valid !== 1'b0) $display("FAIL b2b_rsp_end: got %b expected 0", rsp_valid); else checks_passed++;
    endtask

    task automatic test_wait_states();
        set_cmd(1'b0, 32'h300, 32'h0, 3'd2);
        tick();
        set_cmd(1'b0, 32'h308, 32'h0, 3'd1);
        tick(); cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            hready = 1'b0;
            #1;
            checks_total++; if (cmd_ready !== 1'b0) $display("FAIL ws_cmd_ready[%0d]: got %b expected 0", i, cmd_ready); else checks_passed++;
            checks_total++; if (htrans !== 2'b10 || haddr !== 32'h308 || hsize !== 3'd1) $display("FAIL ws_addr_hold[%0d]: got %b/%h/%0d expected 10/308/1", i, htrans, haddr, hsize); else checks_passed++;
            checks_total++; if (rsp_valid !== 1'b0) $display("FAIL ws_no_rsp[%0d]: got %b expected 0", i, rsp_valid); else checks_passed++;
            tick();
        end
        hready = 1'b1; hrdata = 32'h12345678;
        #1;
        checks_total++; if (htrans !== 2'b10 || haddr !== 32'h308) $display("FAIL ws_addr_last: got %b/%h expected 10/308", htrans, haddr); else checks_passed++;
        tick(); hrdata = 32'hA5A5A5A5;
        checks_total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h12345678) $display("FAIL ws_rsp: got v=%b d=%h expected v=1 d=12345678", rsp_valid, rsp_rdata); else checks_passed++;
        tick(); hrdata = 32'h0;
        checks_total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5A5A5A5) $display("FAIL ws_rsp2: got v=%b d=%h expected v=1 d=a5a5a5a5", rsp_valid, rsp_rdata); else checks_passed++;
        tick();
    endtask

    task automatic test_error();
        set_cmd(1'b1, 32'h400, 32'h0F0F0F0F, 3'd2);
        tick();
        set_cmd(1'b0, 32'h404, 32'h0, 3'd2);
        tick(); cmd_valid = 1'b0;
        hready = 1'b0; hresp = 1'b1;
        checks_total++; if (htrans !== 2'b10 || haddr !== 32'h404) $display("FAIL err_first_cycle: got %b/%h expected 10/404", htrans, haddr); else checks_passed++;
        tick();
        hready = 1'b1; hresp = 1'b1;
        #1;
        checks_total++; if (htrans !== 2'b00) $display("FAIL err_idle: got %b expected 00", htrans); else checks_passed++;
        checks_total++; if (cmd_ready !== 1'b0) $display("FAIL err_cmd_ready: got %b expected 0", cmd_ready); else checks_passed++;
        tick();
        hresp = 1'b0;
        checks_total++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b1) $display("FAIL err_rsp: got v=%b e=%b expected v=1 e=1", rsp_valid, rsp_error); else checks_passed++;
        checks_total++; if (htrans !== 2'b10 || haddr !== 32'h404 || hwrite !== 1'b0) $display("FAIL err_reissue: got %b/%h/%b expected 10/404/0", htrans, haddr, hwrite); else checks_passed++;
        tick(); hrdata = 32'h0BADF00D;
        checks_total++; if (htrans !== 2'b00 || rsp_valid !== 1'b0) $display("FAIL err_once: got htrans=%b v=%b expected 00/0", htrans, rsp_valid); else checks_passed++;
        tick(); hrdata = 32'h0;
        checks_total++; if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_rdata !== 32'h0BADF00D) $display("FAIL err_reissue_rsp: got v=%b e=%b d=%h expected 1/0/0badf00d", rsp_valid, rsp_error, rsp_rdata); else checks_passed++;
        tick();
    endtask

    task automatic test_reset_mid_wait();
        set_cmd(1'b1, 32'h500, 32'h11111111, 3'd2);
        tick();
        set_cmd(1'b0, 32'h504, 32'h0, 3'd2);
        tick(); cmd_valid = 1'b0; hready = 1'b0;
        tick();
        checks_total++; if (hwdata !== 32'h11111111 || haddr !== 32'h504) $display("FAIL rmw_pre: got %h/%h expected 11111111/504", hwdata, haddr); else checks_passed++;
        rst = 1'b1;
        tick();
        checks_total++; if (htrans !== 2'b00 || haddr !== 32'h0 || hwrite !== 1'b0 || hsize !== 3'd0) $display("FAIL rmw_bus: got %b/%h/%b/%0d expected 00/0/0/0", htrans, haddr, hwrite, hsize); else checks_passed++;
        checks_total++; if (hwdata !== 32'h0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) $display("FAIL rmw_data: got %h/%b/%h expected 0/0/0", hwdata, rsp_valid, rsp_rdata); else checks_passed++;
        checks_total++; if (cmd_ready !== 1'b0) $display("FAIL rmw_ready_in_rst: got %b expected 0", cmd_ready); else checks_passed++;
        hready = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks_total++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL rmw_release: got ready=%b v=%b expected 1/0", cmd_ready, rsp_valid); else checks_passed++;
        set_cmd(1'b0, 32'h600, 32'h0, 3'd2);
        tick(); cmd_valid = 1'b0;
        checks_total++; if (htrans !== 2'b10 || haddr !== 32'h600) $display("FAIL rmw_new_addr: got %b/%h expected 10/600", htrans, haddr); else checks_passed++;
        tick(); hrdata = 32'h600D600D;
        checks_total++; if (rsp_valid !== 1'b0) $display("FAIL rmw_dropped: got %b expected 0", rsp_valid); else checks_passed++;
        tick(); hrdata = 32'h0;
        checks_total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h600D600D) $display("FAIL rmw_new_rsp: got v=%b d=%h expected 1/600d600d", rsp_valid, rsp_rdata); else checks_passed++;
        tick();
    endtask

    task automatic test_idle();
        cmd_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks_total++; if (htrans !== 2'b00 || hburst !== 3'b000 || rsp_valid !== 1'b0) $display("FAIL idle[%0d]: got %b/%b/%b expected 00/000/0", i, htrans, hburst, rsp_valid); else checks_passed++;
        end
    endtask

    task automatic test_random();
        cmd_t          cmd_q[$];
        cmd_t          dph_item;
        cmd_t          c;
        bit            dph_busy = 0;
        bit            rsp_due  = 0;
        logic [DW-1:0] rsp_exp  = '0;
        bit            drain;
        for (int cyc = 0; cyc < 400; cyc++) begin
            checks_total++; if (rsp_valid !== rsp_due) $display("FAIL rnd_rsp_valid[%0d]: got %b expected %b", cyc, rsp_valid, rsp_due); else checks_passed++;
            if (rsp_due) begin
                checks_total++; if (rsp_rdata !== rsp_exp || rsp_error !== 1'b0) $display("FAIL rnd_rsp_data[%0d]: got d=%h e=%b expected d=%h e=0", cyc, rsp_rdata, rsp_error, rsp_exp); else checks_passed++;
            end
            if (dph_busy && dph_item.w) begin
                checks_total++; if (hwdata !== dph_item.d) $display("FAIL rnd_hwdata[%0d]: got %h expected %h", cyc, hwdata, dph_item.d); else checks_passed++;
            end
            drain     = (cyc >= 360);
            hready    = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
            hrdata    = $urandom;
            cmd_valid = !drain && ($urandom_range(0, 9) < 7);
            cmd_write = 1'($urandom_range(0, 1));
            cmd_addr  = $urandom;
            cmd_size  = 3'($urandom_range(0, 7));
            cmd_wdata = $urandom;
            #1;
            rsp_due = 0;
            if (dph_busy && hready) begin
                rsp_due  = 1;
                rsp_exp  = dph_item.w ? '0 : hrdata;
                dph_busy = 0;
            end
            if (htrans == 2'b10 && hready) begin
                checks_total++;
                if (cmd_q.size() == 0) begin
                    $display("FAIL rnd_spurious[%0d]: got NONSEQ at %h expected no transfer", cyc, haddr);
                end else begin
                    c = cmd_q.pop_front();
                    if (haddr !== c.a || hwrite !== c.w || hsize !== c.s)
                        $display("FAIL rnd_addr[%0d]: got %h/%b/%0d expected %h/%b/%0d", cyc, haddr, hwrite, hsize, c.a, c.w, c.s);
                    else checks_passed++;
                    dph_item = c;
                    dph_busy = 1;
                end
            end
            if (cmd_valid && cmd_ready) begin
                c.w = cmd_write; c.a = cmd_addr; c.s = cmd_size; c.d = cmd_wdata;
                cmd_q.push_back(c);
            end
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        checks_total++; if (cmd_q.size() != 0 || dph_busy || rsp_due) $display("FAIL rnd_drain: got %0d queued expected 0", cmd_q.size()); else checks_passed++;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0; cmd_wdata = '0;
`ifdef AHB_PROT
        cmd_prot = '0;
`endif
`ifdef AHB_WSTRB
        cmd_strb = '0;
`endif
        hready = 1'b1; hresp = 1'b0; hrdata = '0;
        test_reset();
        test_zero_wait_write();
        test_back_to_back();
        test_wait_states();
        test_error();
        test_reset_mid_wait();
        test_idle();
        test_random();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/ahb_master_ctrl.md
Name: ahb_master_ctrl

Overview:
AHB-Lite initiator that converts a simple command/response handshake from testbench or local logic into single (HBURST=SINGLE) AHB transfers. It pipelines the next address phase under the current data phase. It handles slave wait states and the two-cycle ERROR response. It is the requester-side counterpart of the slave-side user interface (addr/sel/write/wdata/ready/rdata/slave_error) already used in the AHB protocol block.

Parameters:
ADDR_WIDTH, `AHB_ADDR_WIDTH (32), width of haddr and cmd_addr
DATA_WIDTH, `AHB_DATA_WIDTH (32), width of data buses; must be 8/16/32/64

Ports:
clk  input  1  single system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
cmd_write  input  1  1=write, 0=read
cmd_addr  input  ADDR_WIDTH  transfer address
cmd_size  input  3  HSIZE encoding
cmd_wdata  input  DATA_WIDTH  write data
cmd_prot  input  4  protection (only under `AHB_PROT)
cmd_strb  input  DATA_WIDTH/8  byte strobes (only under `AHB_WSTRB)
rsp_valid  output  1  one-cycle pulse per completed transfer
rsp_rdata  output  DATA_WIDTH  read data; 0 for writes
rsp_error  output  1  transfer ended with ERROR
haddr  output  ADDR_WIDTH  AHB address
htrans  output  2  IDLE=2'b00 or NONSEQ=2'b10 only
hwrite  output  1  AHB direction
hsize  output  3  AHB size
hburst  output  3  constant 3'b000 (SINGLE)
hprot  output  4  under `AHB_PROT
hwstrb  output  DATA_WIDTH/8  under `AHB_WSTRB, aligned with hwdata
hwdata  output  DATA_WIDTH  write data, valid in data phase
hready  input  1  bus HREADY (HREADYOUT of selected slave)
hresp  input  1  0=OKAY, 1=ERROR
hrdata  input  DATA_WIDTH  read data

Behaviour:
- Two stage registers: APH (address phase: valid, write, addr, size, prot, wdata, strb) and DPH (data phase: valid, write, wdata, strb).
- All bus outputs are registered from APH/DPH. htrans=NONSEQ iff APH.valid && !cancel, else IDLE.
- cmd_ready = !rst && !cancel && (!APH.valid || hready). Combinational from hready; no other comb path from hready.
- Accept at edge T: APH loaded. Transfer is on the bus during T+1 (haddr/htrans/hwrite/hsize).
- Edge with hready=1: APH moves to DPH (DPH.valid=APH.valid && !cancel). DPH retires. APH is reloaded from an accepted command or cleared.
- Edge with hready=0: APH and DPH hold. haddr/htrans/hwrite/hsize/hwdata stay stable.
- Retire (DPH.valid && hready at edge): next cycle rsp_valid=1, rsp_error=hresp, rsp_rdata = read ? hrdata : 0. hrdata is sampled only at this edge.
- Zero-wait latency: accept T, address T+1, data T+2, rsp_valid T+3. Back-to-back throughput is 1 transfer/cycle.
- The rsp interface has no backpressure. The consumer must always accept.
- Error handling:
  - Edge with hresp=1 && hready=0 && DPH.valid: set cancel. Next cycle (second ERROR cycle) htrans=IDLE. APH content is retained and cmd_ready=0.
  - Edge with hready=1 (end of error): DPH retires with rsp_error=1. cancel clears. The IDLE beat completes and APH stays valid (not moved to DPH).
  - The following cycle re-drives the retained command as NONSEQ, so the cancelled command is reissued exactly once.
- hresp=1 with hready=1 without a preceding hresp=1/hready=0 cycle is a protocol violation: rsp_error=1 is still reported and there is no cancel.
- Reset (sync, any state, including mid wait state or mid error):
  - Next cycle: APH/DPH/cancel=0, htrans=IDLE, haddr=0, hwrite=0, hsize=0, hburst=0, hprot=0, hwstrb=0, hwdata=0.
  - rsp_valid=0, rsp_rdata=0, rsp_error=0; cmd_ready=0 while rst=1.
  - In-flight transfers are dropped with no response.
- No address alignment checking: cmd_addr/cmd_size are passed through unmodified.

Decomposition:
- Shared package ahb_pkg: htrans_e (IDLE/BUSY/NONSEQ/SEQ), hburst_e, hsize_e, HRESP_OKAY/HRESP_ERROR constants. The package is reused by the slave side and the bench. Widths come from definition.sv macros.
- No sub-module is needed. APH/DPH stages and cancel logic stay in one module.

Test Plan:
- Zero-wait write: cmd addr=0x100, wdata=0xDEADBEEF, size=2 at T -> T+1 htrans=NONSEQ haddr=0x100 hwrite=1; T+2 hwdata=0xDEADBEEF; T+3 rsp_valid=1, rsp_error=0.
- Back-to-back: read 0x200 then write 0x204 (0x55AA55AA), cmd_valid held, hready=1 -> NONSEQ on two consecutive cycles; haddr=0x204 in the same cycle hrdata for 0x200 is sampled; two rsp pulses on consecutive cycles.
- Wait states: read 0x300, slave holds hready=0 for 3 cycles, then hready=1 with hrdata=0x12345678 -> pipelined haddr/htrans stable for all 4 cycles; cmd_ready=0 during waits; rsp_rdata=0x12345678.
- Error with pipelined command: write 0x400 in data phase, read 0x404 in address phase; slave gives hresp=1/hready=0 then hresp=1/hready=1 -> htrans=IDLE in second cycle; rsp_error=1 for 0x400; next cycle haddr=0x404 NONSEQ; its rsp_error=0.
- Reset mid-wait: rst=1 during a hready=0 data phase -> next cycle htrans=IDLE, all outputs 0, no rsp_valid; after rst=0, cmd_ready=1 and a new command completes normally.
- Idle bus: cmd_valid=0 for 10 cycles -> htrans=IDLE, hburst=0, rsp_valid=0 throughout.
